// File: rtl/bram_fifo_pkg.sv
// Shared constants for the BlockRAM_1KB FIFO controller: sideband bit positions,
// width-mode encodings and FIFO geometry.
package bram_fifo_pkg;
  localparam int DEPTH = 512;
  localparam int PTR_W = 10;

  localparam int WR_EN_BIT  = 20;
  localparam int WR_TOP_LSB = 16;
  localparam int RD_TOP_LSB = 24;

  localparam logic [1:0] WIDTH_32 = 2'd0;
  localparam logic [1:0] WIDTH_16 = 2'd1;
  localparam logic [1:0] WIDTH_8  = 2'd2;

  // Tile configuration word {C5, C4, rd width, wr width}; C4=0 means per-write enable.
  function automatic logic [5:0] make_cfg(input logic reg_out);
    return {reg_out, 1'b0, WIDTH_16, WIDTH_16};
  endfunction
endpackage

// File: rtl/bram_fifo_skid.sv
// Small register FIFO that holds words already read from the tile, so the head
// of the FIFO is always available to the consumer without RAM latency.
module bram_fifo_skid
  import bram_fifo_pkg::*;
#(
  parameter int SKID_DEPTH = 3,
  parameter int CNT_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [15:0]      push_data,
  input  logic             pop,
  output logic [15:0]      head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] cnt
);
  localparam int IDX_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SKID_DEPTH - 1);

  logic [15:0]      mem_reg [SKID_DEPTH];
  logic [IDX_W-1:0] wr_idx_reg;
  logic [IDX_W-1:0] rd_idx_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      cnt_reg    <= '0;
    end else if (clr) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push)
        wr_idx_reg <= (wr_idx_reg == LAST_IDX) ? '0 : wr_idx_reg + 1'b1;
      if (pop)
        rd_idx_reg <= (rd_idx_reg == LAST_IDX) ? '0 : rd_idx_reg + 1'b1;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Data storage needs no reset; occupancy is tracked by cnt_reg alone.
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && !clr && (wr_idx_reg == IDX_W'(gi)))
        mem_reg[gi] <= push_data;
    end
  end

  assign head_data  = mem_reg[rd_idx_reg];
  assign head_valid = (cnt_reg != '0);
  assign cnt        = cnt_reg;
endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through 512x16 FIFO built on one BlockRAM_1KB tile plus a skid buffer.
// Optional macro BRAM_FIFO_THRESH_EN adds registered almost_full / almost_empty outputs.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int REG_OUT       = 0,
  parameter int SKID_DEPTH    = 3,
  parameter int AFULL_THRESH  = 496,
  parameter int AEMPTY_THRESH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  count,
  output logic [7:0]  bram_wr_addr,
  output logic [31:0] bram_wr_data,
  output logic [7:0]  bram_rd_addr,
  input  logic [31:0] bram_rd_data,
  output logic [5:0]  bram_cfg
`ifdef BRAM_FIFO_THRESH_EN
  ,
  output logic        almost_full,
  output logic        almost_empty
`endif
);
  localparam int L     = 1 + REG_OUT;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_W:0] SKID_LIM = (CNT_W + 1)'(SKID_DEPTH);

  logic [PTR_W-1:0] wp_reg;
  logic [PTR_W-1:0] rp_reg;
  logic [PTR_W-1:0] bram_cnt;
  logic [L-1:0]     pipe_reg;
  logic [CNT_W-1:0] skid_cnt;
  logic [CNT_W-1:0] inflight;
  logic             full;
  logic             push;
  logic             pop;
  logic             issue;
  logic             skid_room;
  logic             unused_rd_hi;

  assign bram_cnt = wp_reg - rp_reg;
  assign full     = (bram_cnt == PTR_W'(DEPTH));
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready && !flush;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++)
      inflight = inflight + CNT_W'(pipe_reg[i]);
  end

  // Reads are only issued when the skid is guaranteed a slot on arrival.
  assign skid_room = ({1'b0, skid_cnt} + {1'b0, inflight}) < SKID_LIM;
  assign issue     = (bram_cnt != '0) && skid_room && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else if (flush) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else begin
      if (push)
        wp_reg <= wp_reg + 1'b1;
      if (issue)
        rp_reg <= rp_reg + 1'b1;
    end
  end

  // Valid shift register tracking reads inside the tile's L-cycle pipeline.
  for (genvar gi = 0; gi < L; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pipe_reg[gi] <= 1'b0;
        else if (flush)
          pipe_reg[gi] <= 1'b0;
        else
          pipe_reg[gi] <= issue;
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pipe_reg[gi] <= 1'b0;
        else if (flush)
          pipe_reg[gi] <= 1'b0;
        else
          pipe_reg[gi] <= pipe_reg[gi-1];
      end
    end
  end

  bram_fifo_skid #(
    .SKID_DEPTH(SKID_DEPTH),
    .CNT_W     (CNT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (pipe_reg[L-1]),
    .push_data (bram_rd_data[15:0]),
    .pop       (pop),
    .head_data (out_data),
    .head_valid(out_valid),
    .cnt       (skid_cnt)
  );

  assign unused_rd_hi = ^bram_rd_data[31:16];

  // The tile registers its read half-select every edge, so rp[8] is always driven.
  always_comb begin
    bram_wr_data             = '0;
    bram_wr_data[15:0]       = in_data;
    bram_wr_data[WR_TOP_LSB] = wp_reg[8];
    bram_wr_data[WR_EN_BIT]  = push;
    bram_wr_data[RD_TOP_LSB] = rp_reg[8];
  end

  assign bram_wr_addr = wp_reg[7:0];
  assign bram_rd_addr = rp_reg[7:0];
  assign bram_cfg     = make_cfg(REG_OUT != 0);
  assign count        = bram_cnt + 10'(skid_cnt) + 10'(inflight);

`ifdef BRAM_FIFO_THRESH_EN
  logic [9:0] count_next;

  // Occupancy only changes through push and pop; internal moves preserve it.
  assign count_next = flush ? 10'd0 : count + 10'(push) - 10'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
    end else begin
      almost_full  <= (count_next >= 10'(AFULL_THRESH));
      almost_empty <= (count_next <= 10'(AEMPTY_THRESH));
    end
  end
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl: instance 0 uses REG_OUT=0, instance 1 REG_OUT=1,
// each attached to a behavioural BlockRAM_1KB model (16-bit modes).
module tb_bram_fifo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic [15:0] in_data      [2];
  logic        in_valid     [2];
  logic        in_ready     [2];
  logic [15:0] out_data     [2];
  logic        out_valid    [2];
  logic        out_ready    [2];
  logic [9:0]  count        [2];
  logic [7:0]  bram_wr_addr [2];
  logic [31:0] bram_wr_data [2];
  logic [7:0]  bram_rd_addr [2];
  logic [31:0] bram_rd_data [2];
  logic [5:0]  bram_cfg     [2];
`ifdef BRAM_FIFO_THRESH_EN
  logic        almost_full  [2];
  logic        almost_empty [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bram_fifo_ctrl #(.REG_OUT(gi)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_data     (in_data[gi]),
      .in_valid    (in_valid[gi]),
      .in_ready    (in_ready[gi]),
      .out_data    (out_data[gi]),
      .out_valid   (out_valid[gi]),
      .out_ready   (out_ready[gi]),
      .count       (count[gi]),
      .bram_wr_addr(bram_wr_addr[gi]),
      .bram_wr_data(bram_wr_data[gi]),
      .bram_rd_addr(bram_rd_addr[gi]),
      .bram_rd_data(bram_rd_data[gi]),
      .bram_cfg    (bram_cfg[gi])
`ifdef BRAM_FIFO_THRESH_EN
      ,
      .almost_full (almost_full[gi]),
      .almost_empty(almost_empty[gi])
`endif
    );

    // Tile model: write captured at posedge, committed at the following negedge;
    // read address and half-select sampled at posedge, optional output register.
    logic [15:0] mem [512];
    logic [8:0]  wa_q;
    logic [15:0] wd_q;
    logic        we_q = 1'b0;
    logic [15:0] rd_q;
    logic [15:0] rd_q2;
    always @(posedge clk) begin
      we_q  <= bram_wr_data[gi][20];
      wa_q  <= {bram_wr_data[gi][16], bram_wr_addr[gi]};
      wd_q  <= bram_wr_data[gi][15:0];
      rd_q  <= mem[{bram_wr_data[gi][24], bram_rd_addr[gi]}];
      rd_q2 <= rd_q;
    end
    always @(negedge clk) begin
      if (we_q)
        mem[wa_q] = wd_q;
    end
    assign bram_rd_data[gi] = {16'h0000, (gi == 1) ? rd_q2 : rd_q};
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 16'h0000;
      out_ready[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    drive_idle();
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks += 5;
      if (in_ready[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", k, in_ready[k]);
      end
      if (out_valid[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]);
      end
      if (count[k] !== 10'd0) begin
        n_fail++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, count[k]);
      end
      if (bram_wr_data[k][20] !== 1'b0) begin
        n_fail++; $display("FAIL reset_wr_en[%0d]: got %b expected 0", k, bram_wr_data[k][20]);
      end
      if (bram_cfg[k] !== ((k == 1) ? 6'h25 : 6'h05)) begin
        n_fail++; $display("FAIL cfg[%0d]: got %h expected %h", k, bram_cfg[k], (k == 1) ? 6'h25 : 6'h05);
      end
    end
    rst = 1'b0;
    drive_idle();
    cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_fail++; $display("FAIL post_reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_latency(input int k, input int lat);
    in_valid[k] = 1'b1;
    in_data[k]  = 16'hA5A5;
    #1;
    n_checks += 3;
    if (bram_wr_data[k][20] !== 1'b1 || bram_wr_data[k][15:0] !== 16'hA5A5) begin
      n_fail++; $display("FAIL push_wr_data[%0d]: got %h expected 00?1A5A5", k, bram_wr_data[k]);
    end
    if (bram_wr_addr[k] !== 8'd0 || bram_wr_data[k][16] !== 1'b0) begin
      n_fail++; $display("FAIL push_wr_addr[%0d]: got %h/%b expected 00/0", k, bram_wr_addr[k], bram_wr_data[k][16]);
    end
    if (bram_wr_data[k][31:25] !== 7'd0 || bram_wr_data[k][23:21] !== 3'd0 || bram_wr_data[k][19:17] !== 3'd0) begin
      n_fail++; $display("FAIL push_sideband_zero[%0d]: got %h", k, bram_wr_data[k]);
    end
    cycle();
    in_valid[k] = 1'b0;
    n_checks++;
    if (count[k] !== 10'd1) begin
      n_fail++; $display("FAIL single_count[%0d]: got %0d expected 1", k, count[k]);
    end
    for (int c = 0; c <= lat; c++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0) begin
        n_fail++; $display("FAIL early_valid[%0d] edge %0d: got %b expected 0", k, c, out_valid[k]);
      end
      cycle();
    end
    n_checks += 3;
    if (out_valid[k] !== 1'b1) begin
      n_fail++; $display("FAIL latency_valid[%0d]: got %b expected 1", k, out_valid[k]);
    end
    if (out_data[k] !== 16'hA5A5) begin
      n_fail++; $display("FAIL single_data[%0d]: got %h expected a5a5", k, out_data[k]);
    end
    if (count[k] !== 10'd1) begin
      n_fail++; $display("FAIL single_count_head[%0d]: got %0d expected 1", k, count[k]);
    end
    out_ready[k] = 1'b1;
    cycle();
    out_ready[k] = 1'b0;
    n_checks += 2;
    if (count[k] !== 10'd0) begin
      n_fail++; $display("FAIL single_count_pop[%0d]: got %0d expected 0", k, count[k]);
    end
    if (out_valid[k] !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_pop[%0d]: got %b expected 0", k, out_valid[k]);
    end
  endtask

  task automatic test_full();
    int exp;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 520; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 16'(i);
      #1;
      n_checks++;
      if (in_ready[0] !== (i < 515)) begin
        n_fail++; $display("FAIL full_in_ready attempt %0d: got %b expected %b", i, in_ready[0], i < 515);
      end
      cycle();
    end
    in_valid[0] = 1'b0;
    n_checks += 3;
    if (count[0] !== 10'd515) begin
      n_fail++; $display("FAIL full_count: got %0d expected 515", count[0]);
    end
    if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h0000) begin
      n_fail++; $display("FAIL full_head: got %b/%h expected 1/0000", out_valid[0], out_data[0]);
    end
    if (bram_wr_data[0][20] !== 1'b0) begin
      n_fail++; $display("FAIL full_wr_en: got %b expected 0", bram_wr_data[0][20]);
    end
    // Push and pop together while full: only the pop happens.
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'hFFFF;
    out_ready[0] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_in_ready: got %b expected 0", in_ready[0]);
    end
    cycle();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    n_checks++;
    if (count[0] !== 10'd514) begin
      n_fail++; $display("FAIL full_pop_count: got %0d expected 514", count[0]);
    end
    exp = 1;
    out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 2000 && exp < 515; cyc++) begin
      #1;
      if (out_valid[0] === 1'b1) begin
        n_checks++;
        if (out_data[0] !== 16'(exp)) begin
          n_fail++; $display("FAIL drain_data: got %h expected %h", out_data[0], 16'(exp));
        end
        exp++;
      end
      cycle();
    end
    out_ready[0] = 1'b0;
    n_checks += 2;
    if (exp != 515) begin
      n_fail++; $display("FAIL drain_timeout: got %0d words expected 515", exp);
    end
    if (count[0] !== 10'd0 || out_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got count %0d valid %b expected 0/0", count[0], out_valid[0]);
    end
  endtask

  task automatic test_stream();
    int sent [2];
    int rcv  [2];
    sent = '{0, 0};
    rcv  = '{0, 0};
    for (int cyc = 0; cyc < 20000 && (rcv[0] < 2000 || rcv[1] < 2000); cyc++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = (sent[k] < 2000) && ($urandom_range(0, 99) < 70);
        in_data[k]   = 16'(sent[k]);
        out_ready[k] = ($urandom_range(0, 99) < 60);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (count[k] !== 10'(sent[k] - rcv[k])) begin
          n_fail++; $display("FAIL stream_count[%0d]: got %0d expected %0d", k, count[k], sent[k] - rcv[k]);
        end
        if (out_valid[k] === 1'b1 && out_ready[k]) begin
          n_checks++;
          if (out_data[k] !== 16'(rcv[k])) begin
            n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", k, out_data[k], 16'(rcv[k]));
          end
          rcv[k]++;
        end
        if (in_valid[k] && in_ready[k] === 1'b1)
          sent[k]++;
      end
      cycle();
    end
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rcv[k] != 2000) begin
        n_fail++; $display("FAIL stream_done[%0d]: got %0d words expected 2000", k, rcv[k]);
      end
    end
  endtask

  task automatic test_clear(input bit use_rst);
    out_ready[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 16'h1000 + 16'(i);
      cycle();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    cycle();
    cycle();
    if (use_rst) begin
      #2;
      rst = 1'b1;
      #1;
      n_checks += 3;
      if (count[0] !== 10'd0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid: got count %0d valid %b ready %b expected 0/0/0", count[0], out_valid[0], in_ready[0]);
      end
      if (bram_wr_data[0][20] !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_wr_en: got %b expected 0", bram_wr_data[0][20]);
      end
      if (bram_rd_addr[0] !== 8'd0) begin
        n_fail++; $display("FAIL rst_mid_rd_addr: got %h expected 00", bram_rd_addr[0]);
      end
      cycle();
      rst = 1'b0;
    end else begin
      flush       = 1'b1;
      in_valid[0] = 1'b1;
      in_data[0]  = 16'hDEAD;
      cycle();
      flush       = 1'b0;
      in_valid[0] = 1'b0;
      n_checks += 2;
      if (count[0] !== 10'd0 || out_valid[0] !== 1'b0) begin
        n_fail++; $display("FAIL flush_clear: got count %0d valid %b expected 0/0", count[0], out_valid[0]);
      end
      if (in_ready[0] !== 1'b1) begin
        n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready[0]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (out_valid[0] !== 1'b0 || count[0] !== 10'd0) begin
        n_fail++; $display("FAIL stale_word use_rst=%0d: got valid %b data %h count %0d expected 0", use_rst, out_valid[0], out_data[0], count[0]);
      end
      cycle();
    end
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'hBEEF;
    cycle();
    in_valid[0] = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL after_clear_data use_rst=%0d: got %b/%h expected 1/beef", use_rst, out_valid[0], out_data[0]);
    end
    out_ready[0] = 1'b1;
    cycle();
    out_ready[0] = 1'b0;
    n_checks++;
    if (count[0] !== 10'd0) begin
      n_fail++; $display("FAIL after_clear_count use_rst=%0d: got %0d expected 0", use_rst, count[0]);
    end
  endtask

`ifdef BRAM_FIFO_THRESH_EN
  task automatic test_thresh();
    int model;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 496; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 16'(i);
      cycle();
      n_checks += 2;
      if (almost_full[0] !== (i + 1 >= 496)) begin
        n_fail++; $display("FAIL almost_full at %0d: got %b expected %b", i + 1, almost_full[0], i + 1 >= 496);
      end
      if (almost_empty[0] !== (i + 1 <= 16)) begin
        n_fail++; $display("FAIL almost_empty fill at %0d: got %b expected %b", i + 1, almost_empty[0], i + 1 <= 16);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    model = 496;
    for (int cyc = 0; cyc < 2000 && model > 16; cyc++) begin
      #1;
      if (out_valid[0] === 1'b1)
        model--;
      cycle();
      n_checks += 2;
      if (almost_empty[0] !== (model <= 16)) begin
        n_fail++; $display("FAIL almost_empty drain at %0d: got %b expected %b", model, almost_empty[0], model <= 16);
      end
      if (almost_full[0] !== (model >= 496)) begin
        n_fail++; $display("FAIL almost_full drain at %0d: got %b expected %b", model, almost_full[0], model >= 496);
      end
    end
    out_ready[0] = 1'b0;
    n_checks++;
    if (model != 16 || count[0] !== 10'd16) begin
      n_fail++; $display("FAIL thresh_drain: got model %0d count %0d expected 16", model, count[0]);
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency(0, 1);
    test_latency(1, 2);
    test_full();
    test_stream();
    test_clear(1'b0);
    test_clear(1'b1);
`ifdef BRAM_FIFO_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
